mem_stg: RTL
============

// Module: mem_stg
// PURPOSE
//  Memory stage of the 5-stage MIPS pipeline; consumer side of exec_mem vld/rdy interface.
//  Registers exec_mem packets, issues data-memory load/store requests (byte enables, lane
//  replication), aligns/sign-extends load data, emits mem_wb packets, one-cycle jump redirect.
// PARAMETERS
//  WORD_W  32  datapath/address width (only 32 supported)
//  BE_W    4   byte enables per word (WORD_W/8)
// PORTS
//  clk             in   1       clock, all state on posedge
//  resetn          in   1       synchronous, active-low reset
//  exec_mem_vld    in   1       upstream packet valid
//  exec_mem_rdy    out  1       stage can accept a packet this cycle
//  exec_mem_pkt    in   pkt     exec_mem_pkg::exec_mem_pkt_t {jmp_vld,addr,mem_op,mem_sz,sgnd,dst_vld,dst_reg,data}
//  mem_wb_vld      out  1       writeback packet valid
//  mem_wb_rdy      in   1       writeback accepts packet
//  mem_wb_pkt      out  pkt     mem_wb_pkg::mem_wb_pkt_t {dst_vld,dst_reg,data}
//  dmem_req_vld    out  1       data memory request valid
//  dmem_req_rdy    in   1       data memory accepts request
//  dmem_req_we     out  1       1=store, 0=load
//  dmem_req_addr   out  32      word-aligned address {addr[31:2],2'b00}
//  dmem_req_be     out  BE_W    byte enables
//  dmem_req_wdata  out  32      lane-replicated store data
//  dmem_rsp_vld    in   1       load data valid (single-cycle pulse)
//  dmem_rsp_rdata  in   32      load data word
//  redirect_vld    out  1       taken branch/jump pulse
//  redirect_addr   out  32      redirect target
//  misalign_err    out  1       misaligned access pulse
//  mem_haz_pkt     out  pkt     haz_pkg::mem_haz_pkt_t {dst_vld,dst_reg,ld_pend,data}
// BEHAVIOUR
//  Reset (resetn=0 at posedge): state=IDLE, packet reg=0; all vld/pulse outputs 0, buses 0.
//  FSM: IDLE -> (accept: NO_MEM->OUT | MEM_LD/MEM_ST aligned->REQ | misaligned->OUT)
//       REQ  -> dmem_req_rdy: store->OUT, load->RSP;  RSP -> dmem_rsp_vld -> OUT
//       OUT  -> mem_wb_rdy: accept new pkt (same decode as IDLE) else IDLE; !rdy: hold OUT.
//  exec_mem_rdy = (state==IDLE) | (state==OUT & mem_wb_rdy). Accept = vld & rdy.
//  Latency: NO_MEM/store w/ rdy=1 -> mem_wb_vld 1 / 2 cycles after accept; load = 2 + rsp delay.
//  Back-to-back NO_MEM packets with mem_wb_rdy=1 sustain 1 pkt/cycle.
//  dmem_req_vld=1 only in REQ; req fields and mem_wb_pkt stable while vld & !rdy.
//  Byte enables: BYTE 4'b0001<<addr[1:0]; HALF 4'b0011<<{addr[1],1'b0}; WORD 4'hF.
//  wdata: BYTE {4{data[7:0]}}, HALF {2{data[15:0]}}, WORD data.
//  Load: select lane by addr[1:0]; zero/sign extend (sgnd) BYTE/HALF to 32b; captured at rsp.
//  Store: mem_wb_pkt.dst_vld=0. NO_MEM: mem_wb_pkt.data = exec_mem_pkt.data.
//  Misaligned (HALF addr[0]=1, WORD addr[1:0]!=0): no dmem req; misalign_err=1 for cycle
//   after accept; mem_wb_pkt.dst_vld=0.
//  jmp_vld=1 on accept: redirect_vld=1, redirect_addr=pkt.addr for exactly the cycle after
//   accept (registered pulse); packet still flows to mem_wb with its own dst fields.
//  mem_haz_pkt: dst_vld/dst_reg of held pkt (0 in IDLE); ld_pend=1 in REQ/RSP;
//   data valid only in OUT.
//  dmem_rsp_vld outside RSP ignored. Reset mid-REQ/RSP drops access; late rsp ignored.
// TESTING
//  1 NO_MEM pkt data=32'h1234, dst_reg=5, mem_wb_rdy=1 -> mem_wb_vld next cycle, data=32'h1234.
//  2 MEM_ST BYTE addr=32'h1003 data=32'hAB -> req addr 32'h1000, be=4'b1000, wdata 32'hABABABAB.
//  3 MEM_LD HALF sgnd=1 addr=2, rsp rdata=32'h8001_0000, rsp 3 cycles late -> data 32'hFFFF8001;
//    ld_pend=1 until rsp.
//  4 MEM_LD WORD addr=32'h1002 -> no dmem_req_vld, misalign_err 1 cycle, mem_wb dst_vld=0.
//  5 jmp_vld=1 addr=32'h0040_0100 -> redirect_vld exactly 1 cycle w/ that addr;
//    mem_wb_rdy=0 for 4 cycles -> pkt held, exec_mem_rdy=0.
//  6 resetn=0 while in RSP, then late dmem_rsp_vld -> IDLE, no mem_wb_vld, outputs at reset.

Source files
------------

// File: rtl/mem_stg.sv
// ============================================================================
// mem_stg : MIPS memory stage - dmem load/store issue, load alignment, jump redirect
// Revision: 1.0
// ============================================================================
`default_nettype none

package exec_mem_pkg;
  localparam logic [1:0] NO_MEM  = 2'd0;
  localparam logic [1:0] MEM_LD  = 2'd1;
  localparam logic [1:0] MEM_ST  = 2'd2;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic        jmp_vld;
    logic [31:0] addr;
    logic [1:0]  mem_op;
    logic [1:0]  mem_sz;
    logic        sgnd;
    logic        dst_vld;
    logic [4:0]  dst_reg;
    logic [31:0] data;
  } exec_mem_pkt_t;
endpackage

package mem_wb_pkg;
  typedef struct packed {
    logic        dst_vld;
    logic [4:0]  dst_reg;
    logic [31:0] data;
  } mem_wb_pkt_t;
endpackage

package haz_pkg;
  typedef struct packed {
    logic        dst_vld;
    logic [4:0]  dst_reg;
    logic        ld_pend;
    logic [31:0] data;
  } mem_haz_pkt_t;
endpackage

module mem_stg #(
  parameter int WORD_W = 32,
  parameter int BE_W   = WORD_W / 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         exec_mem_vld,
  output logic                         exec_mem_rdy,
  input  exec_mem_pkg::exec_mem_pkt_t  exec_mem_pkt,
  output logic                         mem_wb_vld,
  input  logic                         mem_wb_rdy,
  output mem_wb_pkg::mem_wb_pkt_t      mem_wb_pkt,
  output logic                         dmem_req_vld,
  input  logic                         dmem_req_rdy,
  output logic                         dmem_req_we,
  output logic [WORD_W-1:0]            dmem_req_addr,
  output logic [BE_W-1:0]              dmem_req_be,
  output logic [WORD_W-1:0]            dmem_req_wdata,
  input  logic                         dmem_rsp_vld,
  input  logic [WORD_W-1:0]            dmem_rsp_rdata,
  output logic                         redirect_vld,
  output logic [WORD_W-1:0]            redirect_addr,
  output logic                         misalign_err,
  output haz_pkg::mem_haz_pkt_t        mem_haz_pkt
);
  import exec_mem_pkg::*;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]          state_q, state_d;
  exec_mem_pkt_t       pkt_q, pkt_d;
  logic [WORD_W-1:0]   wb_data_q, wb_data_d;
  logic                mis_q, mis_d;
  logic                redirect_vld_q, redirect_vld_d;
  logic [WORD_W-1:0]   redirect_addr_q, redirect_addr_d;
  logic                misalign_err_q, misalign_err_d;

  logic                accept;
  logic                in_mem;
  logic                in_mis;
  logic [1:0]          acc_state;
  logic                is_st;
  logic [WORD_W-1:0]   rsp_shift;
  logic [WORD_W-1:0]   ld_data;

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= S_IDLE;
      pkt_q           <= '0;
      wb_data_q       <= '0;
      mis_q           <= 1'b0;
      redirect_vld_q  <= 1'b0;
      redirect_addr_q <= '0;
      misalign_err_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      pkt_q           <= pkt_d;
      wb_data_q       <= wb_data_d;
      mis_q           <= mis_d;
      redirect_vld_q  <= redirect_vld_d;
      redirect_addr_q <= redirect_addr_d;
      misalign_err_q  <= misalign_err_d;
    end
  end

  // Decode of the incoming packet; the same decode is used from IDLE and OUT
  always_comb begin
    exec_mem_rdy = (state_q == S_IDLE) || ((state_q == S_OUT) && mem_wb_rdy);
    accept       = exec_mem_vld && exec_mem_rdy;
    in_mem       = (exec_mem_pkt.mem_op == MEM_LD) || (exec_mem_pkt.mem_op == MEM_ST);
    in_mis       = ((exec_mem_pkt.mem_sz == SZ_HALF) && exec_mem_pkt.addr[0]) ||
                   ((exec_mem_pkt.mem_sz != SZ_BYTE) && (exec_mem_pkt.mem_sz != SZ_HALF) &&
                    (exec_mem_pkt.addr[1:0] != 2'b00));
    acc_state    = (in_mem && !in_mis) ? S_REQ : S_OUT;
    is_st        = (pkt_q.mem_op == MEM_ST);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = acc_state;
      S_REQ:   if (dmem_req_rdy) state_d = is_st ? S_OUT : S_RSP;
      S_RSP:   if (dmem_rsp_vld) state_d = S_OUT;
      S_OUT:   if (mem_wb_rdy) state_d = accept ? acc_state : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Load lane select and extension
  always_comb begin
    rsp_shift = dmem_rsp_rdata >> {pkt_q.addr[1:0], 3'b000};
    case (pkt_q.mem_sz)
      SZ_BYTE: ld_data = {{24{pkt_q.sgnd & rsp_shift[7]}}, rsp_shift[7:0]};
      SZ_HALF: ld_data = {{16{pkt_q.sgnd & rsp_shift[15]}}, rsp_shift[15:0]};
      default: ld_data = dmem_rsp_rdata;
    endcase
  end

  always_comb begin
    pkt_d           = pkt_q;
    wb_data_d       = wb_data_q;
    mis_d           = mis_q;
    redirect_vld_d  = 1'b0;
    redirect_addr_d = '0;
    misalign_err_d  = 1'b0;
    if (accept) begin
      pkt_d           = exec_mem_pkt;
      wb_data_d       = exec_mem_pkt.data;
      mis_d           = in_mem && in_mis;
      redirect_vld_d  = exec_mem_pkt.jmp_vld;
      redirect_addr_d = exec_mem_pkt.jmp_vld ? exec_mem_pkt.addr : '0;
      misalign_err_d  = in_mem && in_mis;
    end else if ((state_q == S_RSP) && dmem_rsp_vld) begin
      wb_data_d = ld_data;
    end
  end

  // Output decode
  always_comb begin
    mem_wb_vld     = (state_q == S_OUT);
    mem_wb_pkt     = '0;
    if (state_q == S_OUT) begin
      mem_wb_pkt.dst_vld = pkt_q.dst_vld && !is_st && !mis_q;
      mem_wb_pkt.dst_reg = pkt_q.dst_reg;
      mem_wb_pkt.data    = wb_data_q;
    end

    dmem_req_vld   = (state_q == S_REQ);
    dmem_req_we    = 1'b0;
    dmem_req_addr  = '0;
    dmem_req_be    = '0;
    dmem_req_wdata = '0;
    if (state_q == S_REQ) begin
      dmem_req_we   = is_st;
      dmem_req_addr = {pkt_q.addr[WORD_W-1:2], 2'b00};
      case (pkt_q.mem_sz)
        SZ_BYTE: begin
          dmem_req_be    = BE_W'(4'b0001) << pkt_q.addr[1:0];
          dmem_req_wdata = {4{pkt_q.data[7:0]}};
        end
        SZ_HALF: begin
          dmem_req_be    = BE_W'(4'b0011) << {pkt_q.addr[1], 1'b0};
          dmem_req_wdata = {2{pkt_q.data[15:0]}};
        end
        default: begin
          dmem_req_be    = '1;
          dmem_req_wdata = pkt_q.data;
        end
      endcase
    end

    redirect_vld  = redirect_vld_q;
    redirect_addr = redirect_addr_q;
    misalign_err  = misalign_err_q;

    mem_haz_pkt         = '0;
    mem_haz_pkt.dst_vld = (state_q != S_IDLE) && pkt_q.dst_vld;
    mem_haz_pkt.dst_reg = (state_q != S_IDLE) ? pkt_q.dst_reg : 5'd0;
    mem_haz_pkt.ld_pend = (state_q == S_REQ) || (state_q == S_RSP);
    mem_haz_pkt.data    = (state_q == S_OUT) ? wb_data_q : '0;
  end

endmodule

`default_nettype wire
